// File: rtl/dma_byte_writer.sv
// Byte-to-word DMA writer: packs incoming bytes into 32-bit words and writes them to base + 4*index.
// Define DMA_BYTE_WRITER_ENDIAN_SWAP_EN to pack big-endian (lane 0 = bits [31:24]).
module dma_byte_writer (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        i_Start,
   input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
   input  logic [15:0] i_RCC_DMA_ADDR_LOW,
   input  logic [5:0]  i_RCC_BUFFER_LENGTH,
   input  logic [7:0]  i_serialized_input,
   input  logic        i_serialized_input_valid,
   output logic        o_ready,
   output logic [31:0] mem_WR_addr,
   output logic        mem_write_flag,
   output logic [31:0] HWDATA_toMem,
   output logic [1:0]  o_Deserialize_Counter,
   output logic [15:0] o_Bytes_Counter,
   output logic        o_Busy,
   output logic        o_Done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  widx_q, widx_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] bytes_q, bytes_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wflag_q, wflag_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic [31:0] word_ins;

   assign o_ready = (state_q == S_COLLECT);
   assign accept  = o_ready & i_serialized_input_valid;

   // Word buffer with the incoming byte merged into the current lane.
   always_comb begin
      word_ins = word_q;
`ifdef DMA_BYTE_WRITER_ENDIAN_SWAP_EN
      case (lane_q)
         2'd0:    word_ins[31:24] = i_serialized_input;
         2'd1:    word_ins[23:16] = i_serialized_input;
         2'd2:    word_ins[15:8]  = i_serialized_input;
         default: word_ins[7:0]   = i_serialized_input;
      endcase
`else
      case (lane_q)
         2'd0:    word_ins[7:0]   = i_serialized_input;
         2'd1:    word_ins[15:8]  = i_serialized_input;
         2'd2:    word_ins[23:16] = i_serialized_input;
         default: word_ins[31:24] = i_serialized_input;
      endcase
`endif
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      widx_d  = widx_q;
      word_d  = word_q;
      lane_d  = lane_q;
      bytes_d = bytes_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wflag_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               base_d  = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW};
               len_d   = i_RCC_BUFFER_LENGTH;
               widx_d  = '0;
               word_d  = '0;
               lane_d  = '0;
               bytes_d = '0;
               state_d = (i_RCC_BUFFER_LENGTH == 6'd0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               word_d  = word_ins;
               lane_d  = lane_q + 2'd1;
               bytes_d = bytes_q + 16'd1;
               // Write strobe, data and address are registered here so they appear in the WRITE cycle.
               if (lane_q == 2'd3) begin
                  state_d = S_WRITE;
                  wflag_d = 1'b1;
                  wdata_d = word_ins;
                  addr_d  = base_q + {24'd0, widx_q, 2'b00};
                  word_d  = '0;
               end
            end
         end
         S_WRITE: begin
            widx_d  = widx_q + 6'd1;
            state_d = (({1'b0, widx_q} + 7'd1) < {1'b0, len_q}) ? S_COLLECT : S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_COLLECT) || (state_d == S_WRITE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         widx_q  <= '0;
         word_q  <= '0;
         lane_q  <= '0;
         bytes_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wflag_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         word_q  <= word_d;
         lane_q  <= lane_d;
         bytes_q <= bytes_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wflag_q <= wflag_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign mem_WR_addr           = addr_q;
   assign mem_write_flag        = wflag_q;
   assign HWDATA_toMem          = wdata_q;
   assign o_Deserialize_Counter = lane_q;
   assign o_Bytes_Counter       = bytes_q;
   assign o_Busy                = busy_q;
   assign o_Done                = done_q;

endmodule

// File: tb/tb_dma_byte_writer.sv
// Directed bench for dma_byte_writer; expected words follow the lane order of the active build.
module tb_dma_byte_writer;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        i_Start = 1'b0;
   logic [15:0] i_RCC_DMA_ADDR_HIGH = '0;
   logic [15:0] i_RCC_DMA_ADDR_LOW = '0;
   logic [5:0]  i_RCC_BUFFER_LENGTH = '0;
   logic [7:0]  i_serialized_input = '0;
   logic        i_serialized_input_valid = 1'b0;
   logic        o_ready;
   logic [31:0] mem_WR_addr;
   logic        mem_write_flag;
   logic [31:0] HWDATA_toMem;
   logic [1:0]  o_Deserialize_Counter;
   logic [15:0] o_Bytes_Counter;
   logic        o_Busy;
   logic        o_Done;

   dma_byte_writer dut (
      .HCLK                     (HCLK),
      .HRESET                   (HRESET),
      .i_Start                  (i_Start),
      .i_RCC_DMA_ADDR_HIGH      (i_RCC_DMA_ADDR_HIGH),
      .i_RCC_DMA_ADDR_LOW       (i_RCC_DMA_ADDR_LOW),
      .i_RCC_BUFFER_LENGTH      (i_RCC_BUFFER_LENGTH),
      .i_serialized_input       (i_serialized_input),
      .i_serialized_input_valid (i_serialized_input_valid),
      .o_ready                  (o_ready),
      .mem_WR_addr              (mem_WR_addr),
      .mem_write_flag           (mem_write_flag),
      .HWDATA_toMem             (HWDATA_toMem),
      .o_Deserialize_Counter    (o_Deserialize_Counter),
      .o_Bytes_Counter          (o_Bytes_Counter),
      .o_Busy                   (o_Busy),
      .o_Done                   (o_Done)
   );

   always #5 HCLK = ~HCLK;

   int tests = 0;
   int fails = 0;

   // Monitor: everything observed on the falling edge.
   int          cyc = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          last_wr_cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          busy_cnt = 0;

   always @(negedge HCLK) begin
      cyc++;
      if (mem_write_flag) begin
         wr_addr.push_back(mem_WR_addr);
         wr_data.push_back(HWDATA_toMem);
         last_wr_cyc = cyc;
      end
      if (o_Done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (o_Busy) busy_cnt++;
   end

   logic [7:0] tx[0:15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
`ifdef DMA_BYTE_WRITER_ENDIAN_SWAP_EN
      return {b0, b1, b2, b3};
`else
      return {b3, b2, b1, b0};
`endif
   endfunction

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      busy_cnt = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge HCLK);
   endtask

   task automatic start(input logic [31:0] base, input logic [5:0] len);
      @(negedge HCLK);
      i_RCC_DMA_ADDR_HIGH = base[31:16];
      i_RCC_DMA_ADDR_LOW  = base[15:0];
      i_RCC_BUFFER_LENGTH = len;
      i_Start = 1'b1;
      @(negedge HCLK);
      i_Start = 1'b0;
   endtask

   // Holds valid high; a byte is taken on the rising edge following a falling edge that saw o_ready.
   task automatic send(input int first, input int n, output int stalls);
      int i;
      int guard;
      i = 0;
      guard = 0;
      stalls = 0;
      while (i < n && guard < 200) begin
         @(negedge HCLK);
         guard++;
         i_serialized_input = tx[first + i];
         i_serialized_input_valid = 1'b1;
         if (o_ready) i++;
         else stalls++;
      end
      @(negedge HCLK);
      i_serialized_input_valid = 1'b0;
      if (guard >= 200) check("send_timeout", i, n);
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESET = 1'b1;
      i_serialized_input_valid = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ready"}, {31'd0, o_ready}, 32'd0);
      check({pfx, "_addr"}, mem_WR_addr, 32'd0);
      check({pfx, "_wflag"}, {31'd0, mem_write_flag}, 32'd0);
      check({pfx, "_wdata"}, HWDATA_toMem, 32'd0);
      check({pfx, "_lane"}, {30'd0, o_Deserialize_Counter}, 32'd0);
      check({pfx, "_bytes"}, {16'd0, o_Bytes_Counter}, 32'd0);
      check({pfx, "_busy"}, {31'd0, o_Busy}, 32'd0);
      check({pfx, "_done"}, {31'd0, o_Done}, 32'd0);
   endtask

   initial begin
      int stalls;

      // Reset state
      idle(2);
      do_reset();
      check_all_zero("rst");

      // Single word
      clear_mon();
      tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
      start(32'h0000_1000, 6'd1);
      send(0, 4, stalls);
      idle(4);
      check("w1_count", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check("w1_addr", wr_addr[0], 32'h0000_1000);
         check("w1_data", wr_data[0], pack(8'h11, 8'h22, 8'h33, 8'h44));
      end
      check("w1_done_cnt", done_cnt, 1);
      check("w1_done_lat", done_cyc - last_wr_cyc, 1);
      check("w1_bytes", {16'd0, o_Bytes_Counter}, 32'd4);
      check("w1_lane", {30'd0, o_Deserialize_Counter}, 32'd0);

      // Three words with valid held high
      clear_mon();
      for (int k = 0; k < 12; k++) tx[k] = 8'(k + 1);
      start(32'h0000_1000, 6'd3);
      send(0, 12, stalls);
      idle(4);
      check("w3_stalls", stalls, 2);
      check("w3_count", wr_addr.size(), 3);
      if (wr_addr.size() >= 3) begin
         check("w3_addr0", wr_addr[0], 32'h0000_1000);
         check("w3_addr1", wr_addr[1], 32'h0000_1004);
         check("w3_addr2", wr_addr[2], 32'h0000_1008);
         check("w3_data0", wr_data[0], pack(8'h01, 8'h02, 8'h03, 8'h04));
         check("w3_data1", wr_data[1], pack(8'h05, 8'h06, 8'h07, 8'h08));
         check("w3_data2", wr_data[2], pack(8'h09, 8'h0A, 8'h0B, 8'h0C));
      end
      check("w3_bytes", {16'd0, o_Bytes_Counter}, 32'd12);
      check("w3_done_cnt", done_cnt, 1);
      check("w3_hold_addr", mem_WR_addr, 32'h0000_1008);

      // Zero length
      clear_mon();
      start(32'h0000_2000, 6'd0);
      idle(4);
      check("z_count", wr_addr.size(), 0);
      check("z_done_cnt", done_cnt, 1);
      check("z_busy", busy_cnt, 0);

      // Reset after two bytes, then restart
      clear_mon();
      tx[0] = 8'h5A; tx[1] = 8'h6B;
      start(32'h0000_2000, 6'd1);
      send(0, 2, stalls);
      check("r_lane_pre", {30'd0, o_Deserialize_Counter}, 32'd2);
      do_reset();
      check_all_zero("r");
      idle(3);
      check("r_count", wr_addr.size(), 0);
      tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC; tx[3] = 8'hDD;
      start(32'h0000_3000, 6'd1);
      check("r2_lane", {30'd0, o_Deserialize_Counter}, 32'd0);
      check("r2_bytes", {16'd0, o_Bytes_Counter}, 32'd0);
      send(0, 4, stalls);
      idle(4);
      check("r2_count", wr_addr.size(), 1);
      if (wr_addr.size() >= 1) begin
         check("r2_addr", wr_addr[0], 32'h0000_3000);
         check("r2_data", wr_data[0], pack(8'hAA, 8'hBB, 8'hCC, 8'hDD));
      end

      // Address wrap with a stray start mid-transfer
      clear_mon();
      for (int k = 0; k < 8; k++) tx[k] = 8'(8'hA0 + k);
      start(32'hFFFF_FFFC, 6'd2);
      send(0, 2, stalls);
      start(32'h0000_5000, 6'd1);
      send(2, 6, stalls);
      idle(4);
      check("wr_count", wr_addr.size(), 2);
      if (wr_addr.size() >= 2) begin
         check("wr_addr0", wr_addr[0], 32'hFFFF_FFFC);
         check("wr_addr1", wr_addr[1], 32'h0000_0000);
         check("wr_data0", wr_data[0], pack(8'hA0, 8'hA1, 8'hA2, 8'hA3));
         check("wr_data1", wr_data[1], pack(8'hA4, 8'hA5, 8'hA6, 8'hA7));
      end
      check("wr_done_cnt", done_cnt, 1);
      check("wr_bytes", {16'd0, o_Bytes_Counter}, 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dma_byte_writer.md
DMA_BYTE_WRITER -- requirements
Module: dma_byte_writer

Interface
- REQ-001 SHALL have ports (name  direction  width  meaning):
  - HCLK  input  1  sole clock, rising edge.
  - HRESET  input  1  synchronous, active-high reset.
  - i_Start  input  1  one-cycle pulse that starts a transfer.
  - i_RCC_DMA_ADDR_HIGH  input  16  destination base address, bits [31:16].
  - i_RCC_DMA_ADDR_LOW  input  16  destination base address, bits [15:0].
  - i_RCC_BUFFER_LENGTH  input  6  transfer length in 32-bit words (0..63).
  - i_serialized_input  input  8  incoming byte.
  - i_serialized_input_valid  input  1  byte present.
  - o_ready  output  1  block can accept a byte this cycle.
  - mem_WR_addr  output  32  memory write address.
  - mem_write_flag  output  1  one-cycle write strobe.
  - HWDATA_toMem  output  32  memory write data.
  - o_Deserialize_Counter  output  2  byte lane of the next byte.
  - o_Bytes_Counter  output  16  bytes accepted in the current transfer.
  - o_Busy  output  1  transfer in progress.
  - o_Done  output  1  one-cycle completion pulse.
- REQ-002 SHALL have one clock, HCLK; reset HRESET is synchronous and active-high.
- REQ-003 SHALL keep all outputs registered; there are no combinational input-to-output paths except o_ready, which is a decode of the state.

Function
- REQ-004 SHALL implement states IDLE, COLLECT, WRITE and DONE.
- REQ-005 SHALL handle IDLE as follows:
  - o_ready=0, o_Busy=0.
  - On i_Start it latches base={HIGH,LOW} and length, clears the counters, and goes to COLLECT.
  - If the latched length is 0 it goes to DONE instead, with no writes.
- REQ-006 SHALL, in COLLECT, assert o_ready=1 and accept a byte only when o_ready and i_serialized_input_valid are both high in the same cycle.
- REQ-007 SHALL, for each accepted byte:
  - place it in lane o_Deserialize_Counter (lane 0 = bits [7:0], little-endian);
  - increment o_Deserialize_Counter modulo 4;
  - increment o_Bytes_Counter by 1.
- REQ-008 SHALL, when the lane-3 byte is accepted in cycle N, go to WRITE.
- REQ-009 SHALL, in cycle N+1:
  - assert mem_write_flag=1 for exactly one cycle;
  - drive HWDATA_toMem with the assembled word;
  - drive mem_WR_addr = base + 4*word_index, where word_index starts at 0 per transfer.
- REQ-010 SHALL hold o_ready=0 in WRITE; bytes presented in WRITE are not accepted and must be held by the sender.
- REQ-011 SHALL, after WRITE, return to COLLECT if word_index+1 < length, otherwise go to DONE.
- REQ-012 SHALL, in DONE, assert o_Done=1 for one cycle with o_Busy=0, then go to IDLE.
- REQ-013 SHALL assert o_Busy=1 in COLLECT and WRITE only.
- REQ-014 SHALL ignore i_Start while not in IDLE; latched base and length never change mid-transfer.
- REQ-015 SHALL compute address arithmetic modulo 2^32; base 0xFFFFFFFC with word_index 1 yields 0x00000000.
- REQ-016 SHALL hold mem_WR_addr and HWDATA_toMem at their last values when mem_write_flag=0.
- REQ-017 SHALL discard a partial word (fewer than 4 bytes) on reset, with no write issued.

Reset
- REQ-018 SHALL, on HRESET high at a rising HCLK edge, enter IDLE regardless of state, including mid-COLLECT or mid-WRITE.
- REQ-019 SHALL reset these outputs to 0: o_ready, mem_WR_addr, mem_write_flag, HWDATA_toMem, o_Deserialize_Counter, o_Bytes_Counter, o_Busy, o_Done.
- REQ-020 SHALL clear the word buffer, word_index, and latched base and length on reset.

Configuration
- REQ-021 SHALL support macro DMA_BYTE_WRITER_ENDIAN_SWAP_EN:
  - When defined, byte lanes are big-endian: lane 0 = bits [31:24], lane 3 = bits [7:0].
  - When undefined, lanes are little-endian per REQ-007.
  - All other behaviour is identical in both builds.

Verification
- REQ-022 SHALL cover single-word transfer (default build):
  - Stimulus: base=0x0000_1000, length=1, bytes 0x11,0x22,0x33,0x44 back-to-back.
  - Response: one write, addr 0x1000, data 0x44332211; o_Done one cycle later; o_Bytes_Counter=4.
- REQ-023 SHALL cover multi-word transfer with backpressure:
  - Stimulus: length=3, valid held high continuously.
  - Response: o_ready drops one cycle after each 4th byte; writes to 0x1000, 0x1004, 0x1008; no byte lost or duplicated; o_Bytes_Counter=12.
- REQ-024 SHALL cover zero length:
  - Stimulus: length=0, i_Start.
  - Response: no mem_write_flag; o_Done pulses; o_Busy never asserted.
- REQ-025 SHALL cover reset mid-word, then restart:
  - Stimulus: 2 bytes accepted, then HRESET for one cycle, then a new i_Start.
  - Response: all outputs 0 after reset; no write; the next transfer starts at lane 0 and word_index 0.
- REQ-026 SHALL cover address wrap and ignored start:
  - Stimulus: base=0xFFFF_FFFC, length=2, i_Start pulsed again mid-transfer.
  - Response: writes to 0xFFFFFFFC then 0x00000000; second start ignored.
- REQ-027 SHALL cover the DMA_BYTE_WRITER_ENDIAN_SWAP_EN build:
  - Stimulus: bytes 0x11,0x22,0x33,0x44.
  - Response: data 0x11223344.
